// File: rtl/tx_capture_ctrl_if.sv
// tx_capture_ctrl_if: control, capture and readout bundle of the TX sequencer.
// Ports: i_start/i_abort/i_read, i_fir_data in; strobe/enables, readout, status out.
//
// master : drives the commands and the FIR sample (TX top / testbench)
// slave  : the sequencer itself
interface tx_capture_ctrl_if #(
   parameter int NB_DATA = 13
) ();

   logic               i_start;
   logic               i_abort;
   logic               i_read;
   logic [NB_DATA-1:0] i_fir_data;

   logic               o_valid;
   logic               o_prbs_enable;
   logic               o_fir_enable;
   logic [NB_DATA-1:0] o_rd_data;
   logic               o_rd_valid;
   logic               o_rd_last;
   logic               o_done;
   logic [1:0]         o_state;

   modport master (
      output i_start,
      output i_abort,
      output i_read,
      output i_fir_data,
      input  o_valid,
      input  o_prbs_enable,
      input  o_fir_enable,
      input  o_rd_data,
      input  o_rd_valid,
      input  o_rd_last,
      input  o_done,
      input  o_state
   );

   modport slave (
      input  i_start,
      input  i_abort,
      input  i_read,
      input  i_fir_data,
      output o_valid,
      output o_prbs_enable,
      output o_fir_enable,
      output o_rd_data,
      output o_rd_valid,
      output o_rd_last,
      output o_done,
      output o_state
   );

endinterface

// File: rtl/tx_capture_ctrl.sv
// tx_capture_ctrl: strobe/enable sequencer for PRBS->FIR, block capture, readout.
// Ports: clock, i_reset (sync, active-low), bus (tx_capture_ctrl_if.slave).
//
// bus inputs : i_start, i_abort, i_read, i_fir_data
// bus outputs: o_valid, o_prbs_enable, o_fir_enable, o_rd_data,
//              o_rd_valid, o_rd_last, o_done, o_state
module tx_capture_ctrl #(
   parameter int NB_COUNT = 3,
   parameter int NB_DATA  = 13,
   parameter int NB_ADDR  = 4,
   parameter int N_SKIP   = 4
) (
   input logic                clock,
   input logic                i_reset,
   tx_capture_ctrl_if.slave   bus
);

   localparam int DEPTH = 2 ** NB_ADDR;
   localparam logic [3:0] SKIP_MAX = 4'(N_SKIP);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FULL    = 2'd2,
      READ    = 2'd3
   } state_t;

   state_t state;
   state_t state_n;

   logic [NB_COUNT-1:0] count;
   logic                wr_d;
   logic [3:0]          skip;
   logic [NB_ADDR-1:0]  wr_ptr;
   logic [NB_ADDR-1:0]  rd_ptr;

   logic [NB_DATA-1:0]  mem [DEPTH];

   logic [NB_DATA-1:0]  rd_data;
   logic                rd_valid;
   logic                rd_last;

   logic                strobe;
   logic                wr_skip;
   logic                wr_en;
   logic                wr_last;
   logic                rd_end;
   logic                go_cap;
   logic                go_read;

   // Strobe is a pure decode of registered state so the PRBS/FIR
   // see a glitch-free, input-independent i_valid.
   assign strobe = (state == CAPTURE) && (count == '1);

   // wr_d lags the strobe one clock: the FIR registers its output
   // on the strobe edge, so the sample is ready one edge later.
   assign wr_skip = (state == CAPTURE) && wr_d && (skip < SKIP_MAX);
   assign wr_en   = (state == CAPTURE) && wr_d && (skip == SKIP_MAX);
   assign wr_last = wr_en && (wr_ptr == '1);
   assign rd_end  = (state == READ) && (rd_ptr == '1);

   always_comb begin
      state_n = state;
      if (bus.i_abort) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.i_start) state_n = CAPTURE;
            end
            CAPTURE: begin
               if (wr_last) state_n = FULL;
            end
            FULL: begin
               if (bus.i_read)       state_n = READ;
               else if (bus.i_start) state_n = CAPTURE;
            end
            READ: begin
               if (rd_end) state_n = FULL;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Entry events, used to restart the counters for a new pass.
   assign go_cap  = (state_n == CAPTURE) && (state != CAPTURE);
   assign go_read = (state_n == READ) && (state == FULL);

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state    <= IDLE;
         count    <= '0;
         wr_d     <= 1'b0;
         skip     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else if (bus.i_abort) begin
         state    <= IDLE;
         count    <= '0;
         wr_d     <= 1'b0;
         skip     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         state <= state_n;

         // Free-running divider while capturing, parked at 0 otherwise
         // so a new capture always starts phase-aligned to i_start.
         if (state == CAPTURE) begin
            count <= count + 1'b1;
         end else begin
            count <= '0;
         end

         wr_d <= strobe;

         if (go_cap) begin
            skip <= '0;
         end else if (wr_skip) begin
            skip <= skip + 4'd1;
         end

         if (go_cap) begin
            wr_ptr <= '0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         if (go_read) begin
            rd_ptr <= '0;
         end else if (state == READ) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         // rd_data is only loaded in READ so it holds the last word.
         if (state == READ) begin
            rd_data <= mem[rd_ptr];
         end
         rd_valid <= (state == READ);
         rd_last  <= rd_end;
      end
   end

   // Buffer has no reset; its contents survive an abort.
   always_ff @(posedge clock) begin
      if (i_reset && !bus.i_abort && wr_en) begin
         mem[wr_ptr] <= bus.i_fir_data;
      end
   end

   assign bus.o_valid       = strobe;
   assign bus.o_prbs_enable = (state == CAPTURE);
   assign bus.o_fir_enable  = (state == CAPTURE);
   assign bus.o_done        = (state == FULL) || (state == READ);
   assign bus.o_state       = state;
   assign bus.o_rd_data     = rd_data;
   assign bus.o_rd_valid    = rd_valid;
   assign bus.o_rd_last     = rd_last;

endmodule

// File: tb/tb_tx_capture_ctrl.sv
// tb_tx_capture_ctrl: randomized scoreboard bench for tx_capture_ctrl.
// Model works from edge arithmetic: capture start edge, strobe period, skip count.
module tb_tx_capture_ctrl;

   localparam int NB_COUNT = 3;
   localparam int NB_DATA  = 13;
   localparam int NB_ADDR  = 4;
   localparam int N_SKIP   = 4;
   localparam int P        = 1 << NB_COUNT;
   localparam int DEPTH    = 1 << NB_ADDR;
   localparam int FULL_AT  = P * (N_SKIP + DEPTH) + 1;

   logic clock   = 1'b0;
   logic i_reset = 1'b0;

   always #5 clock = ~clock;

   tx_capture_ctrl_if #(.NB_DATA(NB_DATA)) bus ();

   tx_capture_ctrl #(
      .NB_COUNT(NB_COUNT),
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR),
      .N_SKIP  (N_SKIP)
   ) dut (
      .clock  (clock),
      .i_reset(i_reset),
      .bus    (bus)
   );

   typedef struct {
      logic [NB_DATA-1:0] d;
      logic               last;
   } rd_t;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;
   int use_idx = 1;

   logic [NB_DATA-1:0] fir_hist [int];
   logic [NB_DATA-1:0] m_mem [DEPTH];
   rd_t                sb [$];
   logic [NB_DATA-1:0] last_word = '0;

   int m_mode = 0;
   int m_s    = 0;
   int m_r    = -1000;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s at edge %0d: got %0h want %0h",
                     nm, edge_n, act, exp);
      end
   endtask

   task automatic tick();
      logic rs, st, ab, rd;
      int   t;
      logic exp_rdv;
      rs = i_reset;
      st = bus.i_start;
      ab = bus.i_abort;
      rd = bus.i_read;
      t  = edge_n;
      fir_hist[t] = bus.i_fir_data;
      @(posedge clock);
      edge_n++;
      if (!rs || ab) begin
         m_mode = 0;
         m_r    = -1000;
         sb.delete();
         last_word = '0;
      end else begin
         case (m_mode)
            0: if (st) begin
               m_mode = 1;
               m_s    = t;
            end
            1: if (t == m_s + FULL_AT) begin
               m_mode = 2;
               for (int k = 0; k < DEPTH; k++)
                  m_mem[k] = fir_hist[m_s + P * (N_SKIP + 1 + k) + 1];
            end
            2: if (rd) begin
               m_mode = 3;
               m_r    = t;
               for (int k = 0; k < DEPTH; k++) begin
                  rd_t e;
                  e.d    = m_mem[k];
                  e.last = (k == DEPTH - 1);
                  sb.push_back(e);
               end
            end else if (st) begin
               m_mode = 1;
               m_s    = t;
            end
            default: if (t == m_r + DEPTH) m_mode = 2;
         endcase
      end
      #1;
      exp_rdv = (t >= m_r + 1) && (t <= m_r + DEPTH);
      check("state", 32'(bus.o_state), 32'(m_mode));
      check("done", 32'(bus.o_done), 32'(m_mode >= 2));
      check("prbs_en", 32'(bus.o_prbs_enable), 32'(m_mode == 1));
      check("fir_en", 32'(bus.o_fir_enable), 32'(m_mode == 1));
      check("valid", 32'(bus.o_valid),
            32'((m_mode == 1) && ((t - m_s) % P == P - 1)));
      check("rd_valid", 32'(bus.o_rd_valid), 32'(exp_rdv));
      if (m_mode == 0) begin
         check("idle_rd_data", 32'(bus.o_rd_data), 32'd0);
         check("idle_rd_last", 32'(bus.o_rd_last), 32'd0);
      end
      if (use_idx != 0) bus.i_fir_data = NB_DATA'(edge_n);
      else              bus.i_fir_data = NB_DATA'($urandom);
   endtask

   always @(negedge clock) begin
      if (edge_n > 0) begin
         if (bus.o_rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("rd_unexpected", 32'(bus.o_rd_valid), 32'd0);
            end else begin
               rd_t e;
               e = sb.pop_front();
               check("rd_data", 32'(bus.o_rd_data), 32'(e.d));
               check("rd_last", 32'(bus.o_rd_last), 32'(e.last));
               last_word = e.d;
            end
         end else begin
            check("rd_last_idle", 32'(bus.o_rd_last), 32'd0);
            check("rd_hold", 32'(bus.o_rd_data), 32'(last_word));
         end
      end
   end

   task automatic clr();
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_read  = 1'b0;
   endtask

   initial begin
      clr();
      bus.i_fir_data = '0;
      repeat (3) begin
         bus.i_start = 1'($urandom);
         bus.i_abort = 1'($urandom);
         bus.i_read  = 1'($urandom);
         tick();
      end
      i_reset = 1'b1;
      clr();
      repeat (2) tick();

      // capture with index data; read/start noise must be ignored
      bus.i_start = 1'b1;
      tick();
      for (int i = 1; i <= FULL_AT; i++) begin
         bus.i_read  = ($urandom_range(0, 5) == 0);
         bus.i_start = ($urandom_range(0, 5) == 0);
         tick();
      end
      clr();
      repeat (3) tick();

      // read and start together: read wins
      bus.i_read  = 1'b1;
      bus.i_start = 1'b1;
      tick();
      clr();
      repeat (DEPTH + 3) tick();

      // re-read
      bus.i_read = 1'b1;
      tick();
      clr();
      repeat (DEPTH + 3) tick();

      // restart from FULL with random data
      use_idx = 0;
      bus.i_start = 1'b1;
      tick();
      clr();
      repeat (FULL_AT + 2) tick();
      bus.i_read = 1'b1;
      tick();
      clr();
      repeat (DEPTH + 3) tick();

      // abort at edge 100 of a capture
      bus.i_start = 1'b1;
      tick();
      clr();
      repeat (99) tick();
      bus.i_abort = 1'b1;
      tick();
      clr();
      repeat (60) tick();

      // random soak
      repeat (4000) begin
         bus.i_start = ($urandom_range(0, 15) == 0);
         bus.i_read  = ($urandom_range(0, 7) == 0);
         bus.i_abort = ($urandom_range(0, 299) == 0);
         i_reset     = ($urandom_range(0, 999) != 0);
         tick();
      end
      i_reset = 1'b1;
      clr();
      repeat (DEPTH + 4) tick();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
